sha256_core: RTL and testbench
==============================

// Module: sha256_core
// PURPOSE
//  - Single-block SHA-256 hash engine: hashes a fixed-length message of Nl bytes into a 256-bit digest.
//  - Performs padding internally, then runs the 64-round compression iteratively.
//  - Sits behind a simple Enable/Ready pulse handshake; host drives a byte array and reads Hash.
// PARAMETERS (from package sha_const)
//  - Nk  256  digest width in bits.
//  - Nl  32   message length in bytes; legal range 1..55, so the padded message fits one 512-bit block.
//  - Nd  4    number of test vectors (bench only; unused by RTL).
// PORTS
//  - clk     in   1              rising-edge clock
//  - rst     in   1              async reset, active-low
//  - Data    in   8 x [0:Nl-1]   message bytes; Data[0] is the first byte (MSB of W0)
//  - Enable  in   1              start pulse; Data sampled on the same edge
//  - Hash    out  Nk             digest H0..H7 concatenated, H0 in bits [255:224]
//  - Ready   out  1              one-cycle pulse marking Hash valid
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, Ready=0, Hash=0, round counter=0, working regs=0.
//  - States: IDLE -> ROUND -> FINAL -> IDLE.
//  - IDLE: Enable=1 at edge E latches the padded block into W[0..15] and a..h=H_init; go to ROUND, t=0.
//  - Padding: byte Nl=8'h80; zero fill; bytes 56..63 = Nl*8 as a 64-bit big-endian value.
//  - ROUND: one round per cycle. Update T1=h+S1(e)+Ch(e,f,g)+K[t]+W[t]; T2=S0(a)+Maj(a,b,c).
//  - ROUND schedule: a 16-word sliding window computes W[t] for t>=16. Stay in ROUND until t=63.
//  - FINAL: Hash <= {H_init[i]+reg[i]} and Ready <= 1; return to IDLE.
//  - Latency: Ready=1 in the cycle after edge E+65; Ready is exactly 1 cycle wide.
//  - Hash holds its value until the next FINAL or reset.
//  - All adds are mod 2^32; no carries out.
//  - Enable while ROUND/FINAL: ignored, no queueing.
//  - Enable in the same cycle Ready is high: accepted, since the FSM is already IDLE.
//  - Data is only sampled on the accepted Enable edge; changes afterwards have no effect.
//  - Reset mid-operation aborts: no Ready, Hash cleared to 0.
// CONFIGURATION
//  - SHA_UNROLL2_EN defined: two rounds per cycle (chained round instances), t steps by 2.
//    Ready follows edge E+33.
//  - SHA_UNROLL2_EN undefined: one round per cycle, latency as above.
//  - Digest values are identical in both builds.
// STRUCTURE
//  - Package sha_const holds: Nk, Nl, Nd; K[0:63] table; H_init[0:7].
//  - Package sha_const also holds functions rotr, Ch, Maj, S0, S1, s0, s1, and the state enum.
//  - Sub-module sha256_round: combinational single round (a..h, K, W in; a..h out).
//    Instanced once, or twice under SHA_UNROLL2_EN.
// TESTING
//  - Nl=3, Data="abc", Enable pulse -> Ready after 65 cycles;
//    Hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  - Two vectors back-to-back, Enable re-issued the cycle Ready rises -> each Hash matches its golden value.
//  - Enable pulsed again at cycle E+10 with different Data -> ignored;
//    first Hash still matches the original message.
//  - rst low at cycle E+30 -> Ready stays 0, Hash=0; next Enable hashes correctly.
//  - SHA_UNROLL2_EN build, "abc" -> same digest, Ready after 33 cycles.
//  - Nl=32 build, Data file vectors vs hash file -> all Nd digests match the golden values.

Source files
------------

// File: rtl/sha256_core_pkg.sv
// Shared constants, round functions and FSM state type for the single-block SHA-256 engine.
// Optional build macro consumed by the top: SHA_UNROLL2_EN.
package sha_const;

    localparam int Nk = 256;
    localparam int Nl = 32;
    localparam int Nd = 4;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H_init [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } sha_state_t;

    // Working variables a..h; a occupies the top word.
    typedef struct packed {
        logic [31:0] a, b, c, d, e, f, g, h;
    } sha_vars_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] Ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] S0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] S1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_core_round.sv
// One combinational SHA-256 compression round: a..h plus K[t], W[t] in, next a..h out.
module sha256_round
    import sha_const::*;
(
    input  sha_vars_t   cur,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output sha_vars_t   nxt
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1    = cur.h + S1(cur.e) + Ch(cur.e, cur.f, cur.g) + k + w;
        t2    = S0(cur.a) + Maj(cur.a, cur.b, cur.c);
        nxt.a = t1 + t2;
        nxt.b = cur.a;
        nxt.c = cur.b;
        nxt.d = cur.c;
        nxt.e = cur.d + t1;
        nxt.f = cur.e;
        nxt.g = cur.f;
        nxt.h = cur.g;
    end

endmodule

// File: rtl/sha256_core.sv
// Single-block SHA-256 engine with internal padding and iterative compression.
// Define SHA_UNROLL2_EN to run two chained rounds per cycle (same digest, half the round cycles).
module sha256_core
    import sha_const::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    Data [0:Nl-1],
    input  logic          Enable,
    output logic [Nk-1:0] Hash,
    output logic          Ready,
    output sha_state_t    dbg_state
);

    // Handshake: Enable is a one-cycle start pulse, honoured only in IDLE, and
    // Data is captured on that edge; Ready is a one-cycle pulse marking Hash valid,
    // and Hash then holds until the next completion or reset.

    sha_state_t  state;
    sha_state_t  next_state;
    sha_vars_t   vars;
    sha_vars_t   rnd_out;
    logic [31:0] w [0:15];
    logic [5:0]  t;
    logic [511:0] blk;

`ifdef SHA_UNROLL2_EN
    localparam int         STEP   = 2;
    localparam logic [5:0] LAST_T = 6'd62;
    sha_vars_t   mid;
    logic [31:0] w_new0;
    logic [31:0] w_new1;

    sha256_round u_round0 (.cur(vars), .k(K[t]),         .w(w[0]), .nxt(mid));
    sha256_round u_round1 (.cur(mid),  .k(K[t + 6'd1]),  .w(w[1]), .nxt(rnd_out));

    // Both new words depend only on the current window, never on each other.
    assign w_new0 = s1(w[14]) + w[9]  + s0(w[1]) + w[0];
    assign w_new1 = s1(w[15]) + w[10] + s0(w[2]) + w[1];
`else
    localparam int         STEP   = 1;
    localparam logic [5:0] LAST_T = 6'd63;
    logic [31:0] w_new;

    sha256_round u_round0 (.cur(vars), .k(K[t]), .w(w[0]), .nxt(rnd_out));

    assign w_new = s1(w[14]) + w[9] + s0(w[1]) + w[0];
`endif

    // Padded block: message, 0x80 marker, zero fill, 64-bit big-endian bit length.
    always_comb begin
        blk = '0;
        for (int i = 0; i < Nl; i++) begin
            blk[511 - 8*i -: 8] = Data[i];
        end
        blk[511 - 8*Nl -: 8] = 8'h80;
        blk[63:0] = 64'(Nl * 8);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Enable) next_state = ROUND;
            ROUND:   if (t == LAST_T) next_state = FINAL;
            FINAL:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            vars  <= '0;
            t     <= '0;
            Hash  <= '0;
            Ready <= 1'b0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            state <= next_state;
            Ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (Enable) begin
                        for (int j = 0; j < 16; j++) w[j] <= blk[511 - 32*j -: 32];
                        vars <= {H_init[0], H_init[1], H_init[2], H_init[3],
                                 H_init[4], H_init[5], H_init[6], H_init[7]};
                        t    <= '0;
                    end
                end
                ROUND: begin
                    vars <= rnd_out;
                    t    <= t + 6'(STEP);
                    for (int i = 0; i < 16 - STEP; i++) w[i] <= w[i + STEP];
`ifdef SHA_UNROLL2_EN
                    w[14] <= w_new0;
                    w[15] <= w_new1;
`else
                    w[15] <= w_new;
`endif
                end
                FINAL: begin
                    Hash  <= {H_init[0] + vars.a, H_init[1] + vars.b,
                              H_init[2] + vars.c, H_init[3] + vars.d,
                              H_init[4] + vars.e, H_init[5] + vars.f,
                              H_init[6] + vars.g, H_init[7] + vars.h};
                    Ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_sha256_core.sv
// Self-checking bench for sha256_core against a queue-based SHA-256 reference model.
module tb_sha256_core;
    import sha_const::*;

    typedef logic [7:0] msg_t [0:Nl-1];
    typedef byte unsigned bq_t [$];

`ifdef SHA_UNROLL2_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 65;
`endif
    localparam logic [255:0] ABC_GOLD =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    localparam logic [31:0] TK [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk;
    logic         rst;
    msg_t         Data;
    logic         Enable;
    logic [255:0] Hash;
    logic         Ready;
    sha_state_t   dbg_state;

    logic [255:0] exp_q [$];
    logic [255:0] last_exp;
    int           checks;
    int           errors;

    sha256_core dut (
        .clk       (clk),
        .rst       (rst),
        .Data      (Data),
        .Enable    (Enable),
        .Hash      (Hash),
        .Ready     (Ready),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_sha(input bq_t msg);
        bq_t          p;
        logic [63:0]  bits;
        logic [31:0]  hv [0:7];
        logic [31:0]  wv [0:63];
        logic [31:0]  va, vb, vc, vd, ve, vf, vg, vh, x1, x2;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int b = 0; b < p.size(); b += 64) begin
            for (int j = 0; j < 16; j++)
                wv[j] = {p[b+4*j], p[b+4*j+1], p[b+4*j+2], p[b+4*j+3]};
            for (int j = 16; j < 64; j++)
                wv[j] = (rr(wv[j-2], 17) ^ rr(wv[j-2], 19) ^ (wv[j-2] >> 10)) + wv[j-7]
                      + (rr(wv[j-15], 7) ^ rr(wv[j-15], 18) ^ (wv[j-15] >> 3)) + wv[j-16];
            {va, vb, vc, vd, ve, vf, vg, vh} = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
            for (int r = 0; r < 64; r++) begin
                x1 = vh + (rr(ve, 6) ^ rr(ve, 11) ^ rr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + TK[r] + wv[r];
                x2 = (rr(va, 2) ^ rr(va, 13) ^ rr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
                vh = vg; vg = vf; vf = ve; ve = vd + x1;
                vd = vc; vc = vb; vb = va; va = x1 + x2;
            end
            hv[0] += va; hv[1] += vb; hv[2] += vc; hv[3] += vd;
            hv[4] += ve; hv[5] += vf; hv[6] += vg; hv[7] += vh;
        end
        return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
    endfunction

    function automatic bq_t to_q(input msg_t m);
        bq_t q;
        for (int i = 0; i < Nl; i++) q.push_back(m[i]);
        return q;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic rand_msg(output msg_t m);
        for (int i = 0; i < Nl; i++) m[i] = 8'($urandom_range(0, 255));
    endtask

    // Call at a negedge; returns just after the accepting edge with Data scrambled.
    task automatic drive_start(input msg_t m);
        Data   = m;
        Enable = 1'b1;
        exp_q.push_back(ref_sha(to_q(m)));
        @(posedge clk);
        #1;
        Enable = 1'b0;
        for (int i = 0; i < Nl; i++) Data[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_ready(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (Ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic collect(input string tag, input int exp_lat);
        int           n;
        bit           ok;
        logic [255:0] e;
        wait_ready(n, ok);
        check({tag, "_seen"}, 256'(ok), 256'(1));
        check({tag, "_lat"}, 256'(n), 256'(exp_lat));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check({tag, "_hash"}, Hash, e);
        last_exp = e;
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (Ready) pulses++;
        end
    endtask

    task automatic run_one(input string tag, input msg_t m);
        @(negedge clk);
        drive_start(m);
        collect(tag, LAT);
        @(negedge clk);
        check({tag, "_width"}, 256'(Ready), '0);
        repeat (4) @(negedge clk);
        check({tag, "_hold"}, Hash, last_exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        msg_t         m1, m2;
        logic [255:0] dummy;
        int           pulses;
        bq_t          abc;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        Enable = 1'b0;
        for (int i = 0; i < Nl; i++) Data[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 256'(Ready), '0);
        check("rst_hash", Hash, '0);
        check("rst_state", 256'(dbg_state), 256'(IDLE));
        rst = 1'b1;

        abc = '{8'h61, 8'h62, 8'h63};
        check("model_abc", ref_sha(abc), ABC_GOLD);

        // Boundary byte patterns, then random messages
        for (int v = 0; v < 6; v++) begin
            if (v == 0)      for (int i = 0; i < Nl; i++) m1[i] = 8'h00;
            else if (v == 1) for (int i = 0; i < Nl; i++) m1[i] = 8'hff;
            else             rand_msg(m1);
            run_one($sformatf("vec%0d", v), m1);
        end

        // Back-to-back: second Enable issued while Ready is high
        rand_msg(m1);
        rand_msg(m2);
        @(negedge clk);
        drive_start(m1);
        collect("b2b0", LAT);
        drive_start(m2);
        collect("b2b1", LAT);
        @(negedge clk);
        check("b2b_width", 256'(Ready), '0);

        // Enable during ROUND with different data must be ignored
        rand_msg(m1);
        rand_msg(m2);
        @(negedge clk);
        drive_start(m1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        Data   = m2;
        Enable = 1'b1;
        @(posedge clk);
        #1;
        Enable = 1'b0;
        collect("ign", LAT - 10);
        count_pulses(LAT + 15, pulses);
        check("ign_no_second", 256'(pulses), '0);

        // Reset mid-operation aborts
        rand_msg(m1);
        @(negedge clk);
        drive_start(m1);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        dummy = exp_q.pop_front();
        @(negedge clk);
        check("abort_hash", Hash, '0);
        check("abort_ready", 256'(Ready), '0);
        check("abort_state", 256'(dbg_state), 256'(IDLE));
        rst = 1'b1;
        count_pulses(LAT + 15, pulses);
        check("abort_no_ready", 256'(pulses), '0);
        check("abort_hash_kept0", Hash, '0);

        rand_msg(m1);
        run_one("post_rst", m1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
